// File: rtl/sim_ctrl_pkg.sv
// Shared constants for the simulation-control responder: register offsets,
// STATUS bit positions, FSM encoding and the watchdog exit code.
package sim_ctrl_pkg;

    localparam logic [1:0] REG_TOHOST  = 2'd0;
    localparam logic [1:0] REG_CONSOLE = 2'd1;
    localparam logic [1:0] REG_CYCLE   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int unsigned STAT_HALTED    = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 2;
    localparam int unsigned STAT_OVERFLOW  = 3;
    localparam int unsigned STAT_MISALIGN  = 4;
    localparam int unsigned STAT_TIMEOUT   = 5;
    localparam int unsigned STAT_COUNT_LSB = 8;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    localparam logic [30:0] TIMEOUT_EXIT = 31'h7FFF_FFFF;

endpackage

// File: rtl/sim_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO for console bytes; a push into a
// full FIFO is accepted only when a pop frees a slot on the same edge.
module sim_ctrl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             push_ok, pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    // Head is forced to zero when empty so the port is clean after reset.
    assign rdata   = empty ? '0 : mem[rp];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wp] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wp <= wp + 1'b1;
            if (pop_ok)
                rp <= rp + 1'b1;
            if (push_ok & ~pop_ok)
                count <= count + 1'b1;
            else if (~push_ok & pop_ok)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/sim_ctrl_dev.sv
// Memory-mapped simulation-control responder: TOHOST halt, console FIFO,
// cycle counter and STATUS. Optional watchdog under SIM_CTRL_TIMEOUT_EN.
module sim_ctrl_dev
    import sim_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  halt,
    output logic [30:0]           exit_code,
    output logic                  cons_valid,
    output logic [7:0]            cons_data,
    input  logic                  cons_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e      state_q, state_d;
    logic [30:0] exit_q, exit_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cnt_q;
    logic        ovf_q, mis_q;

    logic [1:0]  reg_sel;
    logic        wr_ev, aligned, wr_ok, tohost_wr, push, pop;
    logic        f_full, f_empty;
    logic [CW-1:0] f_count;
    logic [31:0] status;
    logic        unused_bits;

    assign reg_sel   = addr[3:2];
    assign wr_ev     = sel & mem_write & ~reset;
    assign aligned   = (addr[1:0] == 2'b00);
    assign wr_ok     = wr_ev & aligned;
    assign tohost_wr = wr_ok & (reg_sel == REG_TOHOST) & wdata[0];
    assign push      = wr_ok & (reg_sel == REG_CONSOLE);
    assign pop       = cons_valid & cons_ready;

`ifdef SIM_CTRL_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    assign unused_bits = ^addr[ADDR_WIDTH-1:4];
`else
    assign unused_bits = ^{addr[ADDR_WIDTH-1:4], 32'(TIMEOUT_CYCLES)};
`endif

    // A TOHOST halt on the same edge as the watchdog takes priority.
    always_comb begin
        state_d   = state_q;
        exit_d    = exit_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (tohost_wr) begin
                    state_d = ST_HALTED;
                    exit_d  = wdata[31:1];
                end
`ifdef SIM_CTRL_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d   = ST_HALTED;
                    exit_d    = TIMEOUT_EXIT;
                    timeout_d = 1'b1;
                end
`endif
            end
            ST_HALTED: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            exit_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            exit_q    <= exit_d;
            timeout_q <= timeout_d;
            if (state_q == ST_RUN)
                cnt_q <= cnt_q + 32'd1;
            if (wr_ev & ~aligned)
                mis_q <= 1'b1;
            if (push & f_full & ~pop)
                ovf_q <= 1'b1;
        end
    end

    sim_ctrl_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata[7:0]),
        .rdata (cons_data),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    assign cons_valid = ~f_empty;
    assign halt       = (state_q == ST_HALTED);
    assign exit_code  = exit_q;

    always_comb begin
        status                          = '0;
        status[STAT_HALTED]             = halt;
        status[STAT_FULL]               = f_full;
        status[STAT_EMPTY]              = f_empty;
        status[STAT_OVERFLOW]           = ovf_q;
        status[STAT_MISALIGN]           = mis_q;
        status[STAT_TIMEOUT]            = timeout_q;
        status[STAT_COUNT_LSB +: 8]     = 8'(f_count);
    end

    always_comb begin
        rdata = '0;
        if (sel & mem_read) begin
            case (reg_sel)
                REG_CYCLE:  rdata = cnt_q;
                REG_STATUS: rdata = status;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_ctrl_dev.sv
// Directed self-checking bench for sim_ctrl_dev; inputs change on negedge,
// outputs are sampled in the low phase away from the active edge.
module tb_sim_ctrl_dev;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset, sel, mem_write, mem_read, cons_ready;
    logic [AW-1:0] addr;
    logic [31:0]   wdata, rdata;
    logic          halt, cons_valid;
    logic [30:0]   exit_code;
    logic [7:0]    cons_data;

    int n_chk  = 0;
    int n_pass = 0;

    sim_ctrl_dev #(
        .ADDR_WIDTH     (AW),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .halt       (halt),
        .exit_code  (exit_code),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .cons_ready (cons_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called at a negedge; leaves reset low at a negedge.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge; the store commits on the next posedge.
    task automatic store(input logic [AW-1:0] a, input logic [31:0] d);
        sel = 1'b1; mem_write = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic load(input logic [AW-1:0] a, output logic [31:0] d);
        sel = 1'b1; mem_read = 1'b1; addr = a;
        #1;
        d = rdata;
        sel = 1'b0; mem_read = 1'b0; addr = '0;
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b1; sel = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        cons_ready = 1'b0; addr = '0; wdata = '0;
        @(negedge clk);

        // Reset state
        do_reset(5);
        reset = 1'b1;
        #1;
        chk("rst_halt",  {31'd0, halt}, 32'd0);
        chk("rst_exit",  {1'b0, exit_code}, 32'd0);
        chk("rst_valid", {31'd0, cons_valid}, 32'd0);
        chk("rst_data",  {24'd0, cons_data}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Cycle counter and idle status
        repeat (9) @(negedge clk);
        load(11'h008, v); chk("cycle_9", v, 32'd9);
        load(11'h00C, v); chk("status_idle", v, 32'h0000_0004);

        // Console FWFT: 'H','i'
        store(11'h004, 32'h0000_0048);
        chk("cons_push_valid", {31'd0, cons_valid}, 32'd1);
        store(11'h004, 32'hFFFF_FF69);
        chk("cons_head_H", {24'd0, cons_data}, 32'h48);
        load(11'h00C, v); chk("status_cnt2", v, 32'h0000_0200);
        load(11'h004, v); chk("console_rd0", v, 32'd0);
        cons_ready = 1'b1;
        #1 chk("cons_pop_H", {24'd0, cons_data}, 32'h48);
        @(negedge clk);
        #1 chk("cons_pop_i", {24'd0, cons_data}, 32'h69);
        @(negedge clk);
        #1 chk("cons_drained", {31'd0, cons_valid}, 32'd0);
        cons_ready = 1'b0;

        // Overflow: fifth byte dropped
        do_reset(2);
        for (int i = 0; i < 5; i++) store(11'h004, 32'h41 + i);
        load(11'h00C, v); chk("ovf_status", v, 32'h0000_040A);
        cons_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("ovf_drain%0d", i), {24'd0, cons_data}, 32'h41 + i);
            @(negedge clk);
        end
        #1 chk("ovf_empty", {31'd0, cons_valid}, 32'd0);
        cons_ready = 1'b0;

        // Full with simultaneous pop: both accepted
        do_reset(2);
        for (int i = 0; i < 4; i++) store(11'h004, 32'h41 + i);
        cons_ready = 1'b1;
        store(11'h004, 32'h55);
        cons_ready = 1'b0;
        load(11'h00C, v); chk("full_pop_status", v, 32'h0000_0402);
        cons_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("fp_drain%0d", i), {24'd0, cons_data},
                   (i == 3) ? 32'h55 : 32'h42 + i);
            @(negedge clk);
        end
        cons_ready = 1'b0;

        // Misaligned store ignored, then TOHOST 7 -> exit 3
        do_reset(2);
        store(11'h002, 32'h0000_0001);
        chk("mis_no_halt", {31'd0, halt}, 32'd0);
        load(11'h00C, v); chk("mis_status", v, 32'h0000_0014);
        store(11'h000, 32'h0000_0006);
        chk("even_tohost_ign", {31'd0, halt}, 32'd0);
        store(11'h000, 32'h0000_0007);
        chk("halt7", {31'd0, halt}, 32'd1);
        chk("exit3", {1'b0, exit_code}, 32'd3);
        load(11'h00C, v); chk("halt_status", v, 32'h0000_0015);

        // Halt at cycle 20, counter freezes, later TOHOST ignored
        do_reset(2);
        repeat (20) @(negedge clk);
        chk("pre_halt", {31'd0, halt}, 32'd0);
        store(11'h000, 32'h0000_0001);
        chk("halt1", {31'd0, halt}, 32'd1);
        chk("exit0", {1'b0, exit_code}, 32'd0);
        repeat (5) @(negedge clk);
        load(11'h008, v); chk("cycle_frozen", v, 32'd21);
        store(11'h000, 32'h0000_0005);
        chk("exit_hold", {1'b0, exit_code}, 32'd0);
        store(11'h004, 32'h0000_0021);
        chk("halted_push", {23'd0, cons_valid, cons_data}, 32'h121);

        // Reset mid-operation clears everything
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_halt", {31'd0, halt}, 32'd0);
        chk("midrst_valid", {23'd0, cons_valid, cons_data}, 32'd0);
        load(11'h008, v); chk("midrst_cycle", v, 32'd0);
        reset = 1'b0;

`ifdef SIM_CTRL_TIMEOUT_EN
        do_reset(2);
        repeat (49) @(negedge clk);
        chk("to_not_yet", {31'd0, halt}, 32'd0);
        @(negedge clk);
        chk("to_halt", {31'd0, halt}, 32'd1);
        chk("to_exit", {1'b0, exit_code}, 32'h7FFF_FFFF);
        load(11'h00C, v); chk("to_status", v, 32'h0000_0025);
        load(11'h008, v); chk("to_cycle", v, 32'd50);
        do_reset(1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("to_rst_halt", {31'd0, halt}, 32'd0);
        chk("to_rst_exit", {1'b0, exit_code}, 32'd0);
        load(11'h00C, v); chk("to_rst_status", v, 32'h0000_0004);
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
